ibex_mem_subsystem: RTL and testbench



---
 rtl/ibex_mem_subsystem.sv | 98 +++++++++
 tb/tb_ibex_mem_subsystem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_subsystem.sv
// Shared code/data RAM for an Ibex test platform: fixed-priority arbitration of the
// fetch and load/store ports onto one single-port word RAM with one-cycle read latency.
module ibex_mem_subsystem #(
   parameter  int Depth = 16384,
   localparam int AW    = $clog2(Depth)
) (
   input  logic        clk_sys,
   input  logic        rst_sys_n,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o
);

   localparam logic [1:0] OWN_NONE  = 2'd0;
   localparam logic [1:0] OWN_INSTR = 2'd1;
   localparam logic [1:0] OWN_DATA  = 2'd2;

   logic [31:0]   mem [Depth];

   logic          ram_req;
   logic          ram_we;
   logic [3:0]    ram_be;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_wdata;

   logic [1:0]    owner_d;
   logic [1:0]    owner_q;
   logic [31:0]   rdata_q;

   // Byte offset and bits above the RAM size are dropped, so addresses alias modulo Depth*4.
   logic unused_addr;
   assign unused_addr = ^{instr_addr_i[31:AW+2], instr_addr_i[1:0],
                          data_addr_i[31:AW+2],  data_addr_i[1:0]};

   assign data_gnt_o  = data_req_i;
   assign instr_gnt_o = instr_req_i & ~data_req_i;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ram_req   = 1'b0;
      ram_we    = 1'b0;
      ram_be    = 4'b0000;
      ram_idx   = '0;
      ram_wdata = '0;
      owner_d   = OWN_NONE;
      if (data_req_i) begin
         ram_req   = 1'b1;
         ram_we    = data_we_i;
         ram_be    = data_be_i;
         ram_idx   = data_addr_i[AW+1:2];
         ram_wdata = data_wdata_i;
         owner_d   = OWN_DATA;
      end else if (instr_req_i) begin
         ram_req   = 1'b1;
         ram_idx   = instr_addr_i[AW+1:2];
         owner_d   = OWN_INSTR;
      end
   end

   // NOTE: the RAM array is deliberately absent from the reset branch; holding reset simply
   // blocks the write path, and non-blocking updates make a store return the pre-write word.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         owner_q <= OWN_NONE;
         rdata_q <= '0;
      end else begin
         owner_q <= owner_d;
         if (ram_req) begin
            rdata_q <= mem[ram_idx];
            if (ram_we) begin
               for (int b = 0; b < 4; b++) begin
                  if (ram_be[b]) begin
                     mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign instr_rvalid_o = (owner_q == OWN_INSTR);
   assign data_rvalid_o  = (owner_q == OWN_DATA);
   assign instr_rdata_o  = rdata_q;
   assign data_rdata_o   = rdata_q;

endmodule

// File: tb/tb_ibex_mem_subsystem.sv
// Directed plus short randomised bench for ibex_mem_subsystem; a scoreboard queue holds the
// response expected for each granted request and a sparse word model tracks RAM contents.
module tb_ibex_mem_subsystem;

   localparam int Depth = 16384;
   localparam int AW    = $clog2(Depth);

   logic        clk_sys = 1'b0;
   logic        rst_sys_n;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;

   typedef struct {
      logic        is_data;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [int];
   int          n_checks = 0;
   int          n_fail   = 0;

   ibex_mem_subsystem #(.Depth(Depth)) dut (
      .clk_sys        (clk_sys),
      .rst_sys_n      (rst_sys_n),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] addr);
      return int'(addr[AW+1:2]);
   endfunction

   // One clock cycle: drive inputs, check grants, schedule the expected response, then
   // check whatever response the DUT presents right after the edge.
   task automatic do_cycle(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic dwe, input logic [3:0] be,
                           input logic [31:0] daddr, input logic [31:0] wdata);
      exp_t e;
      int   k;
      logic [31:0] w;
      instr_req_i  = ireq;
      instr_addr_i = iaddr;
      data_req_i   = dreq;
      data_we_i    = dwe;
      data_be_i    = be;
      data_addr_i  = daddr;
      data_wdata_i = wdata;
      #1;
      check("data_gnt",  {31'b0, data_gnt_o},  {31'b0, dreq});
      check("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, ireq & ~dreq});
      if (dreq) begin
         k          = idx_of(daddr);
         e.is_data  = 1'b1;
         e.chk_data = model.exists(k);
         e.data     = model.exists(k) ? model[k] : 32'h0;
         sb.push_back(e);
         if (dwe) begin
            w = model.exists(k) ? model[k] : 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            if (model.exists(k) || be == 4'hF) model[k] = w;
         end
      end else if (ireq) begin
         k          = idx_of(iaddr);
         e.is_data  = 1'b0;
         e.chk_data = model.exists(k);
         e.data     = model.exists(k) ? model[k] : 32'h0;
         sb.push_back(e);
      end
      @(posedge clk_sys);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("data_rvalid",  {31'b0, data_rvalid_o},  {31'b0, e.is_data});
         check("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, ~e.is_data});
         if (e.chk_data) begin
            if (e.is_data) check("data_rdata",  data_rdata_o,  e.data);
            else           check("instr_rdata", instr_rdata_o, e.data);
         end
      end else begin
         check("idle_data_rvalid",  {31'b0, data_rvalid_o},  32'h0);
         check("idle_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      end
   endtask

   task automatic idle();
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] addrs [4];
      addrs[0] = 32'h0000_0300;
      addrs[1] = 32'h0000_0304;
      addrs[2] = 32'h0000_0308;
      addrs[3] = 32'h0000_030C;

      // Reset: outputs quiet, grants still follow inputs, a store presented is not executed.
      rst_sys_n    = 1'b0;
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0000_0020;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = 4'h0;
      data_addr_i  = 32'h0;
      data_wdata_i = 32'h0;
      #1;
      check("rst_instr_gnt", {31'b0, instr_gnt_o}, 32'h1);
      data_req_i   = 1'b1;
      data_we_i    = 1'b1;
      data_be_i    = 4'hF;
      data_addr_i  = 32'h0000_0400;
      data_wdata_i = 32'hBAD0_BAD0;
      #1;
      check("rst_data_gnt", {31'b0, data_gnt_o}, 32'h1);
      repeat (2) @(posedge clk_sys);
      #1;
      check("rst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      check("rst_data_rvalid",  {31'b0, data_rvalid_o},  32'h0);
      check("rst_rdata",        data_rdata_o,            32'h0);
      instr_req_i = 1'b0;
      data_req_i  = 1'b0;
      data_we_i   = 1'b0;
      rst_sys_n   = 1'b1;
      idle();

      // Preload word index 8 through the data port, then fetch it.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h0000_0013);
      idle();
      do_cycle(1'b1, 32'h0000_0080 - 32'h0000_0060, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();

      // Full-word store then load of the same word in the next cycle.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
      check("model_deadbeef", model[idx_of(32'h0000_1000)], 32'hDEAD_BEEF);

      // Single-lane store, then a no-lane store that must still respond.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0001, 32'h0000_1000, 32'h0000_00AA);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0,    32'h0000_1000, 32'h0);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h0000_1000, 32'hFFFF_FFFF);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0,    32'h0000_1002, 32'h0);
      check("model_deadbeaa", model[idx_of(32'h0000_1000)], 32'hDEAD_BEAA);

      // Contention: data wins, held fetch granted the next cycle.
      do_cycle(1'b1, 32'h0000_0020, 1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
      do_cycle(1'b1, 32'h0000_0020, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0);
      idle();

      // Address aliasing modulo Depth*4.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0001_0004, 32'h1122_3344);
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
      check("model_alias", model[idx_of(32'h0000_0004)], 32'h1122_3344);

      // Pipelined random mix over a small pre-written set.
      for (int i = 0; i < 4; i++)
         do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, addrs[i], 32'h0101_0101 * (i + 1));
      for (int i = 0; i < 24; i++) begin
         do_cycle(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), addrs[$urandom_range(0, 3)], $urandom);
      end
      idle();

      // Reset mid-transaction: granted load is dropped, store under reset is ignored.
      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_2000, 32'hA5A5_A5A5);
      data_req_i  = 1'b1;
      data_we_i   = 1'b0;
      data_addr_i = 32'h0000_2000;
      #1;
      check("midrst_gnt", {31'b0, data_gnt_o}, 32'h1);
      rst_sys_n = 1'b0;
      #1;
      check("midrst_data_rvalid",  {31'b0, data_rvalid_o},  32'h0);
      check("midrst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      data_we_i    = 1'b1;
      data_be_i    = 4'hF;
      data_wdata_i = 32'hFFFF_FFFF;
      @(posedge clk_sys);
      #1;
      check("inrst_data_rvalid",  {31'b0, data_rvalid_o},  32'h0);
      check("inrst_instr_rvalid", {31'b0, instr_rvalid_o}, 32'h0);
      check("inrst_rdata",        data_rdata_o,            32'h0);
      data_req_i = 1'b0;
      data_we_i  = 1'b0;
      rst_sys_n  = 1'b1;
      sb.delete();
      idle();
      idle();
      do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
